dot_vector_sequencer: RTL and testbench



---
 rtl/dot_vector_sequencer_if.sv | 30 +++
 rtl/dot_vector_sequencer.sv | 118 +++++++++++
 tb/tb_dot_vector_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dot_vector_sequencer_if.sv
// Handshake/bus bundle between the dot-product sequencer and its environment:
// operand write port, run control, status and the MAC-facing stream.
interface dot_vector_sequencer_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          mac_clr;
  logic          mac_enable;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [AW:0]   elem_count;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, len,
    input  busy, done, mac_clr, mac_enable, mac_a, mac_b, elem_count
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, len,
    output busy, done, mac_clr, mac_enable, mac_a, mac_b, elem_count
  );
endinterface

// File: rtl/dot_vector_sequencer.sv
// Feeds operand pairs from two small vectors into the MAC accumulator.
// Optional `define ZERO_SKIP_EN suppresses mac_enable for zero products.
module dot_vector_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  dot_vector_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  logic [DW-1:0] mem_a_q [DEPTH];
  logic [DW-1:0] mem_b_q [DEPTH];

  state_t        state_q;
  logic [AW:0]   len_q;
  logic [AW:0]   idx_q;
  logic [AW:0]   elem_count_q;
  logic          busy_q;
  logic          done_q;
  logic          mac_clr_q;
  logic          mac_en_q;
  logic [DW-1:0] mac_a_q;
  logic [DW-1:0] mac_b_q;

  logic [AW:0]   len_eff_d;
  logic [DW-1:0] op_a_d;
  logic [DW-1:0] op_b_d;
  logic          issue_en_d;

  always_comb begin
    len_eff_d = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
    op_a_d    = mem_a_q[idx_q[AW-1:0]];
    op_b_d    = mem_b_q[idx_q[AW-1:0]];
`ifdef ZERO_SKIP_EN
    issue_en_d = (op_a_d != '0) && (op_b_d != '0);
`else
    issue_en_d = 1'b1;
`endif
  end

  // NOTE: the operand arrays carry no reset so they map onto plain RAM and
  // keep their contents across rst; writes are dropped while a run is active.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_q) begin
      if (bus.wr_sel) mem_b_q[bus.wr_addr] <= bus.wr_data;
      else            mem_a_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // NOTE: all state and outputs update with <= so every register samples the
  // pre-edge values; blocking assignments here would chain updates in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      elem_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
    end else begin
      mac_clr_q <= 1'b0;
      done_q    <= 1'b0;
      mac_en_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q        <= len_eff_d;
            idx_q        <= '0;
            elem_count_q <= '0;
            busy_q       <= 1'b1;
            mac_clr_q    <= 1'b1;
            state_q      <= CLEAR;
          end
        end
        // Outputs are registered, so the pair for the next STREAM cycle is
        // launched from the cycle before it (CLEAR or the previous STREAM).
        CLEAR, STREAM: begin
          if (idx_q == len_q) begin
            state_q <= DRAIN;
          end else begin
            state_q  <= STREAM;
            mac_en_q <= issue_en_d;
            mac_a_q  <= op_a_d;
            mac_b_q  <= op_b_d;
            idx_q    <= idx_q + (AW+1)'(1);
            if (issue_en_d) elem_count_q <= elem_count_q + (AW+1)'(1);
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mac_clr    = mac_clr_q;
  assign bus.mac_enable = mac_en_q;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.elem_count = elem_count_q;

endmodule

// File: tb/tb_dot_vector_sequencer.sv
// Self-checking bench for dot_vector_sequencer: directed plan plus random runs
// compared against a cycle-indexed reference built from the run timing rules.
module tb_dot_vector_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic clk;
  logic rst;
  int   passed;
  int   failed;
  int   total;
  int   ra [DEPTH];
  int   rb [DEPTH];
  int   hold_a;
  int   hold_b;

  dot_vector_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  dot_vector_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit product_counts(input int a, input int b);
`ifdef ZERO_SKIP_EN
    return (a != 0) && (b != 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic wr(input bit sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = AW'(addr);
    bus.wr_data = DW'(data);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    if (sel) rb[addr] = data;
    else     ra[addr] = data;
  endtask

  task automatic load(input int a [DEPTH], input int b [DEPTH]);
    for (int i = 0; i < DEPTH; i++) begin
      wr(1'b0, i, a[i]);
      wr(1'b1, i, b[i]);
    end
  endtask

  // Starts a run and checks every cycle from acceptance to the first IDLE cycle.
  // hold_start keeps start high for the whole run and pokes a write mid-run.
  task automatic run(input int len, input bit hold_start);
    int l_eff;
    int sum_exp;
    int sum_obs;
    int cnt;
    bit exp_en;
    l_eff   = (len > DEPTH) ? DEPTH : len;
    sum_exp = 0;
    sum_obs = 0;
    cnt     = 0;
    for (int i = 0; i < l_eff; i++) sum_exp += ra[i] * rb[i];
    bus.len   = (AW+1)'(len);
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    for (int c = 1; c <= l_eff + 3; c++) begin
      exp_en = 1'b0;
      if (c >= 2 && c <= l_eff + 1) begin
        hold_a = ra[c-2];
        hold_b = rb[c-2];
        exp_en = product_counts(hold_a, hold_b);
        if (exp_en) cnt++;
      end
      check("busy",       32'(bus.busy),       32'(1));
      check("mac_clr",    32'(bus.mac_clr),    32'(c == 1));
      check("mac_enable", 32'(bus.mac_enable), 32'(exp_en));
      check("done",       32'(bus.done),       32'(c == l_eff + 3));
      check("mac_a",      32'(bus.mac_a),      hold_a);
      check("mac_b",      32'(bus.mac_b),      hold_b);
      check("elem_count", 32'(bus.elem_count), cnt);
      if (bus.mac_enable) sum_obs += int'(bus.mac_a) * int'(bus.mac_b);
      if (hold_start && c == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = DW'(~ra[0]);
      end
      if (c == 3) bus.wr_en = 1'b0;
      if (c == l_eff + 3) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    check("idle_busy",       32'(bus.busy),       32'(0));
    check("idle_done",       32'(bus.done),       32'(0));
    check("idle_enable",     32'(bus.mac_enable), 32'(0));
    check("held_elem_count", 32'(bus.elem_count), cnt);
    check("dot_product",     sum_obs,             sum_exp);
  endtask

  initial begin
    int va [DEPTH];
    int vb [DEPTH];
    passed = 0; failed = 0; total = 0;
    hold_a = 0; hold_b = 0;
    for (int i = 0; i < DEPTH; i++) begin ra[i] = 0; rb[i] = 0; end
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",       32'(bus.busy),       0);
    check("rst_done",       32'(bus.done),       0);
    check("rst_mac_clr",    32'(bus.mac_clr),    0);
    check("rst_mac_enable", 32'(bus.mac_enable), 0);
    check("rst_mac_a",      32'(bus.mac_a),      0);
    check("rst_mac_b",      32'(bus.mac_b),      0);
    check("rst_elem_count", 32'(bus.elem_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4-element run, expected dot product 70
    va = '{1, 2, 3, 4, 0, 0, 0, 0};
    vb = '{5, 6, 7, 8, 0, 0, 0, 0};
    load(va, vb);
    run(4, 1'b0);
    check("plan1_sum", 32'(ra[0]*rb[0] + ra[1]*rb[1] + ra[2]*rb[2] + ra[3]*rb[3]), 70);

    // Empty run
    run(0, 1'b0);

    // len above DEPTH clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin va[i] = 1; vb[i] = 1; end
    load(va, vb);
    run(12, 1'b0);

    // Full-scale operands, start held as a level and a write attempted mid-run
    for (int i = 0; i < DEPTH; i++) begin va[i] = 255; vb[i] = 255; end
    load(va, vb);
    run(8, 1'b1);
    run(8, 1'b0);

    // Reset during the third STREAM cycle, then rerun on retained memory
    va = '{3, 9, 17, 200, 5, 6, 7, 8};
    vb = '{11, 4, 2, 1, 9, 9, 9, 9};
    load(va, vb);
    bus.len = (AW+1)'(8);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_enable", 32'(bus.mac_enable), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hold_a = 0; hold_b = 0;
    check("post_rst_busy",       32'(bus.busy),       0);
    check("post_rst_enable",     32'(bus.mac_enable), 0);
    check("post_rst_elem_count", 32'(bus.elem_count), 0);
    check("post_rst_mac_a",      32'(bus.mac_a),      0);
    run(2, 1'b0);

    // Zero operands: skipped with ZERO_SKIP_EN, streamed otherwise; sum is 22
    va = '{0, 3, 0, 2, 0, 0, 0, 0};
    vb = '{9, 4, 7, 5, 0, 0, 0, 0};
    load(va, vb);
    run(4, 1'b0);

    // Randomized contents and lengths
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        va[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        vb[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      end
      load(va, vb);
      run(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
